// File: rtl/gigatron_pkg.sv
// Shared controller constants: button bit positions within a pad report and the turbo mask.
package gigatron_pkg;

    localparam int unsigned PAD_BITS  = 8;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    // Turbo-enabled A/B only read as pressed while the shared turbo phase is high.
    function automatic logic [PAD_BITS-1:0] apply_turbo(
        input logic [PAD_BITS-1:0] buttons,
        input logic [1:0]          turbo_en,
        input logic                turbo_phase
    );
        logic [PAD_BITS-1:0] eff;
        eff = buttons;
        if (turbo_en[0]) eff[BTN_A] = buttons[BTN_A] & turbo_phase;
        if (turbo_en[1]) eff[BTN_B] = buttons[BTN_B] & turbo_phase;
        return eff;
    endfunction

endpackage

// File: rtl/famicom_pad_shifter.sv
// One emulated controller: parallel load of the active-low report, LSB-first serial shift-out.
module famicom_pad_shifter
    import gigatron_pkg::*;
#(
    parameter int unsigned SHIFT_LEN = 24,
    parameter logic        FILL_BIT  = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [PAD_BITS-1:0] i_buttons,
    input  logic [1:0]          i_turbo_en,
    input  logic                i_turbo_phase,
    input  logic                i_load,
    input  logic                i_shift,
    output logic                o_data
);

    logic [SHIFT_LEN-1:0] r_shift;
    logic [SHIFT_LEN-1:0] w_load_val;
    logic [PAD_BITS-1:0]  w_eff;

    always_comb begin
        w_eff                     = apply_turbo(i_buttons, i_turbo_en, i_turbo_phase);
        w_load_val                = {SHIFT_LEN{FILL_BIT}};
        w_load_val[PAD_BITS-1:0]  = ~w_eff;
    end

    // Load has priority so a pulse edge during the latch cannot consume a bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '1;
        end else if (i_load) begin
            r_shift <= w_load_val;
        end else if (i_shift) begin
            r_shift <= {FILL_BIT, r_shift[SHIFT_LEN-1:1]};
        end
    end

    assign o_data = r_shift[0];

endmodule

// File: rtl/famicom_pad_serializer.sv
// Multi-pad Famicom controller emulation on the Gigatron latch/pulse/data interface.
module famicom_pad_serializer
    import gigatron_pkg::*;
#(
    parameter int unsigned NUM_PADS      = 2,
    parameter int unsigned SHIFT_LEN     = 24,
    parameter logic        FILL_BIT      = 1'b1,
    parameter int unsigned TURBO_LATCHES = 4
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [NUM_PADS*PAD_BITS-1:0] joy_buttons,
    input  logic [NUM_PADS*2-1:0]        turbo_en,
    input  logic                         famicom_latch,
    input  logic                         famicom_pulse,
    output logic [NUM_PADS-1:0]          famicom_data,
    output logic [15:0]                  latch_count
);

    localparam int unsigned CNT_W = (TURBO_LATCHES > 1) ? $clog2(TURBO_LATCHES) : 1;

    logic             r_latch_meta, r_latch_s, r_latch_d;
    logic             r_pulse_meta, r_pulse_s, r_pulse_d, r_pulse_rise;
    logic [CNT_W-1:0] r_turbo_cnt;
    logic             r_turbo_phase;
    logic [15:0]      r_latch_count;
    logic             w_latch_rise;
    logic             w_load;
    logic             w_shift;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_latch_meta <= 1'b0;
            r_latch_s    <= 1'b0;
            r_latch_d    <= 1'b0;
            r_pulse_meta <= 1'b0;
            r_pulse_s    <= 1'b0;
            r_pulse_d    <= 1'b0;
            r_pulse_rise <= 1'b0;
        end else begin
            r_latch_meta <= famicom_latch;
            r_latch_s    <= r_latch_meta;
            r_latch_d    <= r_latch_s;
            r_pulse_meta <= famicom_pulse;
            r_pulse_s    <= r_pulse_meta;
            r_pulse_d    <= r_pulse_s;
            r_pulse_rise <= r_pulse_s & ~r_pulse_d;
        end
    end

    assign w_latch_rise = r_latch_s & ~r_latch_d;
    assign w_load       = r_latch_s;
    assign w_shift      = r_pulse_rise & ~r_latch_s;

    // The phase flips on the TURBO_LATCHES-th latch; the first load of that latch still
    // sees the old phase, later loads in the same latch window see the new one.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= 1'b0;
            r_latch_count <= '0;
        end else if (w_latch_rise) begin
            r_latch_count <= r_latch_count + 16'd1;
            if (r_turbo_cnt == CNT_W'(TURBO_LATCHES - 1)) begin
                r_turbo_cnt   <= '0;
                r_turbo_phase <= ~r_turbo_phase;
            end else begin
                r_turbo_cnt <= r_turbo_cnt + 1'b1;
            end
        end
    end

    assign latch_count = r_latch_count;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        famicom_pad_shifter #(
            .SHIFT_LEN (SHIFT_LEN),
            .FILL_BIT  (FILL_BIT)
        ) u_shifter (
            .i_clk         (clk_sys),
            .i_rst         (reset),
            .i_buttons     (joy_buttons[p*PAD_BITS +: PAD_BITS]),
            .i_turbo_en    (turbo_en[2*p +: 2]),
            .i_turbo_phase (r_turbo_phase),
            .i_load        (w_load),
            .i_shift       (w_shift),
            .o_data        (famicom_data[p])
        );
    end

endmodule

// File: tb/tb_famicom_pad_serializer.sv
// Bench for famicom_pad_serializer: vector table, hand sequences and a random read model.
module tb_famicom_pad_serializer;

    localparam int TL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] joy;
    logic [3:0]  tur;
    logic        latch, pulse;
    logic [1:0]  data1, data0;
    logic [15:0] cnt1, cnt0;

    always #5 clk = ~clk;

    famicom_pad_serializer #(
        .NUM_PADS(2), .SHIFT_LEN(24), .FILL_BIT(1'b1), .TURBO_LATCHES(TL)
    ) dut1 (
        .clk_sys(clk), .reset(rst), .joy_buttons(joy), .turbo_en(tur),
        .famicom_latch(latch), .famicom_pulse(pulse),
        .famicom_data(data1), .latch_count(cnt1)
    );

    famicom_pad_serializer #(
        .NUM_PADS(2), .SHIFT_LEN(24), .FILL_BIT(1'b0), .TURBO_LATCHES(TL)
    ) dut0 (
        .clk_sys(clk), .reset(rst), .joy_buttons(joy), .turbo_en(tur),
        .famicom_latch(latch), .famicom_pulse(pulse),
        .famicom_data(data0), .latch_count(cnt0)
    );

    typedef struct {
        logic [15:0] joy;
        logic [3:0]  tur;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
    } vec_t;

    vec_t        tbl [6];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_lat = 0;
    logic [63:0] s1 [2];
    logic [63:0] s0 [2];
    logic [1:0]  first1, first0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: serial stream = inverted effective buttons, then fill bits forever.
    function automatic logic [63:0] model_bits(input logic [7:0] b, input logic [1:0] t,
                                               input int latches, input logic fill,
                                               input int nbits);
        logic        ph;
        logic [7:0]  e;
        logic [63:0] r;
        ph = ((latches / TL) % 2) != 0;
        e  = b;
        if (t[0]) e[0] = b[0] & ph;
        if (t[1]) e[1] = b[1] & ph;
        r = '0;
        for (int i = 0; i < nbits; i++) r[i] = (i < 8) ? ~e[i] : fill;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        latch = 1'b0;
        pulse = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        n_lat = 0;
    endtask

    // One latch window (first-load sample taken 3 cycles after rise), then nbits serial reads.
    task automatic read_frame(input int nbits);
        @(negedge clk);
        latch = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        first1 = data1;
        first0 = data0;
        repeat (7) @(negedge clk);
        latch = 1'b0;
        repeat (6) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            s1[p] = '0;
            s0[p] = '0;
        end
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                pulse = 1'b1;
                repeat (8) @(negedge clk);
                pulse = 1'b0;
                repeat (8) @(negedge clk);
            end
            for (int p = 0; p < 2; p++) begin
                s1[p][i] = data1[p];
                s0[p][i] = data0[p];
            end
        end
        n_lat++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h0303, 4'h5, 8'hFD, 8'hFD};
        tbl[1] = '{16'h8001, 4'h0, 8'hFE, 8'h7F};
        tbl[2] = '{16'h0000, 4'h0, 8'hFF, 8'hFF};
        tbl[3] = '{16'hFFFF, 4'h0, 8'h00, 8'h00};
        tbl[4] = '{16'h5AA5, 4'h0, 8'h5A, 8'hA5};
        tbl[5] = '{16'h0C30, 4'h0, 8'hCF, 8'hF3};

        rst = 1'b1; joy = '0; tur = '0; latch = 1'b0; pulse = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data1", data1, 2'b11);
        check("reset_data0", data0, 2'b11);
        check("reset_count", cnt1, 16'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_data", data1, 2'b11);

        // Vector table
        do_reset();
        for (int k = 0; k < 6; k++) begin
            joy = tbl[k].joy;
            tur = tbl[k].tur;
            read_frame(8);
            check($sformatf("tbl%0d_p0", k), s1[0][7:0], tbl[k].exp0);
            check($sformatf("tbl%0d_p1", k), s1[1][7:0], tbl[k].exp1);
            check($sformatf("tbl%0d_fill0_p0", k), s0[0][7:0], tbl[k].exp0);
            check($sformatf("tbl%0d_fill0_p1", k), s0[1][7:0], tbl[k].exp1);
            check($sformatf("tbl%0d_first", k), first1, {tbl[k].exp1[0], tbl[k].exp0[0]});
        end
        check("tbl_count", cnt1, 16'd6);

        // Latch/pulse collision: pulse edge inside latch window must not shift
        joy = 16'h0101; tur = 4'h0;
        @(negedge clk); latch = 1'b1;
        repeat (4) @(negedge clk); pulse = 1'b1;
        repeat (8) @(negedge clk); pulse = 1'b0;
        repeat (4) @(negedge clk); latch = 1'b0;
        repeat (8) @(negedge clk);
        n_lat++;
        check("collision_data1", data1, 2'b00);
        check("collision_data0", data0, 2'b00);

        // Overrun: 30 pulses, fill bits beyond the report never wrap
        joy = 16'h0000;
        read_frame(31);
        check("overrun_fill1_p0", s1[0][30:0], 31'h7FFF_FFFF);
        check("overrun_fill1_p1", s1[1][30:0], 31'h7FFF_FFFF);
        check("overrun_fill0_p0", s0[0][30:0], 31'h0000_00FF);
        check("overrun_fill0_p1", s0[1][30:0], 31'h0000_00FF);

        // Reset mid-shift
        joy = 16'hFFFF;
        read_frame(3);
        check("midshift_data", data1, 2'b00);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_data1", data1, 2'b11);
        check("async_reset_data0", data0, 2'b11);
        check("async_reset_count", cnt1, 16'h0);
        @(negedge clk); rst = 1'b0; n_lat = 0;
        repeat (5) @(negedge clk);
        check("post_reset_hold", data1, 2'b11);
        read_frame(1);
        check("post_reset_first_latch", s1[0][0] | s1[1][0], 1'b0);
        check("post_reset_count", cnt1, 16'd1);

        // Turbo: A held with turbo on pad 0, 16 frames
        do_reset();
        joy = 16'h0001; tur = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            read_frame(1);
            check($sformatf("turbo_frame%0d", k + 1), first1[0], ((k / 4) % 2 == 0) ? 1'b1 : 1'b0);
        end
        check("turbo_count", cnt1, 16'd16);

        // Random frames against the reference model
        do_reset();
        for (int it = 0; it < 30; it++) begin
            @(negedge clk);
            joy = 16'($urandom);
            tur = 4'($urandom);
            read_frame(10);
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rnd%0d_p%0d_fill1", it, p), s1[p][9:0],
                      model_bits(joy[8*p +: 8], tur[2*p +: 2], n_lat, 1'b1, 10));
                check($sformatf("rnd%0d_p%0d_fill0", it, p), s0[p][9:0],
                      model_bits(joy[8*p +: 8], tur[2*p +: 2], n_lat, 1'b0, 10));
                check($sformatf("rnd%0d_p%0d_first", it, p), first1[p],
                      model_bits(joy[8*p +: 8], tur[2*p +: 2], n_lat - 1, 1'b1, 1));
            end
            check($sformatf("rnd%0d_count", it), cnt1, 16'(n_lat));
        end

        // latch_count wrap
        @(negedge clk);
        force dut1.r_latch_count = 16'hFFFF;
        @(negedge clk);
        release dut1.r_latch_count;
        @(negedge clk);
        check("wrap_preload", cnt1, 16'hFFFF);
        read_frame(1);
        check("wrap_count", cnt1, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
